multi_cycle_sequencer: RTL and testbench
========================================

Name: multi_cycle_sequencer

Overview:
- Multi-cycle successor to the single-cycle RV32I top: an FSM that owns the PC and instruction register, and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Memory accesses use req/ready handshakes with variable latency.
- Consumes decoded controls from control_unit plus datapath results; gates RegWEn and memory strobes per phase.
- Adds parametrised XLEN, reset vector, memory timeout and fault trapping.

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT_CYCLES, 16, max cycles a memory request may wait for ready (>=1)
- CNT_W, 64, width of performance counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- Inst  out  32  latched instruction register to control_unit/datapath
- dec_RegWEn  in  1  decoded register write enable
- dec_MemRW  in  1  decoded store (1) / non-store (0)
- dec_WBSel  in  2  decoded writeback select (0 = mem => load)
- dec_Jump  in  1  decoded JAL/JALR
- branch_taken  in  1  datapath branch compare result, qualified by Branch
- alu_result  in  XLEN  ALU output (address / jump target)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write strobe
- dmem_addr  out  XLEN  latched ALU result
- dmem_ready  in  1  data access complete
- dmem_rdata  in  XLEN  load data
- load_data  out  XLEN  latched load data for WB mux
- RegWEn  out  1  gated register-file write enable (one-cycle pulse)
- pc  out  XLEN  current PC
- fault  out  1  sticky trap indicator
- fault_cause  out  2  0 none, 1 imem timeout, 2 misaligned target, 3 dmem timeout
- cycle_count  out  CNT_W  cycles since reset
- instret_count  out  CNT_W  retired instructions

Behaviour:
- Reset (rst high at edge): state=IDLE, pc=RESET_PC, Inst=0, load_data=0, dmem_addr=0, wait counter=0, fault=0, fault_cause=0, counters=0.
- All strobes (imem_req, dmem_req, dmem_we, RegWEn) are Moore outputs, 0 in IDLE and TRAP. Reset mid-operation aborts any request at the next edge; no retirement and no write occurs.
- IDLE -> FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc held stable.
  - imem_ready=1 at an edge: Inst<=imem_rdata, next state DECODE.
  - ready on the first FETCH cycle is zero-wait.
- DECODE: one cycle; controls settle from Inst. -> EXEC.
- EXEC: dmem_addr<=alu_result.
  - Load (dec_WBSel==0) or store (dec_MemRW==1): -> MEM.
  - Otherwise: -> WB.
- MEM: dmem_req=1, dmem_we=dec_MemRW.
  - On dmem_ready: load_data<=dmem_rdata (loads only), -> WB.
- WB: RegWEn=dec_RegWEn for exactly this cycle; instret_count+1.
  - Next pc: if dec_Jump or branch_taken, pc<=alu_result with bit0 cleared; else pc<=pc+4, wrapping modulo 2^XLEN.
  - -> FETCH.
- Misaligned target: in WB, if the redirect target bit1 is set, then RegWEn=0, pc unchanged, no retire, -> TRAP with cause 2.
- Timeout: wait counter clears on entering FETCH/MEM and increments each cycle ready=0. Requests stay asserted for at most TIMEOUT_CYCLES cycles; if ready is still 0 on the last, -> TRAP with cause 1 (FETCH) or 3 (MEM).
- Ready arriving on the final allowed cycle completes normally.
- TRAP: fault=1, fault_cause held, all strobes 0, pc frozen. Exit only by rst.
- Latency, zero-wait: non-memory instruction = 4 cycles FETCH-to-FETCH; load/store = 5 cycles. Each wait cycle adds 1.
- Ready asserted while req=0 is ignored.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle rst=0, including TRAP.
  - instret_count increments on each successful WB.
  - Both wrap at 2^CNT_W.
- Undefined: both outputs constant 0; no counter flops.

Test Plan:
- Reset release, imem_ready=1 always, Inst=ADDI (dec_RegWEn=1): imem_req high at cycle 1 with imem_addr=0; RegWEn pulses at cycle 4; next fetch at cycle 5 with addr=4.
- Load with dmem_ready delayed 3 cycles, dmem_rdata=0xDEADBEEF: dmem_req high 4 cycles, dmem_we=0, load_data=0xDEADBEEF, RegWEn pulse, total 8 cycles.
- Branch with branch_taken=1, alu_result=0x100: pc=0x100 after WB, no RegWEn; with branch_taken=0, pc=pc+4.
- imem_ready held 0: imem_req high exactly 16 cycles, then fault=1, fault_cause=1, strobes 0. Assert rst: fault clears, fetch restarts at RESET_PC.
- JALR with alu_result=0x103: target 0x102 misaligned -> fault_cause=2, RegWEn never asserted, pc unchanged. With alu_result=0x101: pc=0x100, retire normally.
- With PERF_COUNTERS_EN, run 3 ALU instructions from reset: instret_count=3; cycle_count=13 at the third WB+1. Without the macro, both read 0.

Source files
------------

// File: rtl/multi_cycle_sequencer.sv
// multi_cycle_sequencer: multi-cycle RV32I control sequencer.
// Owns the PC and the instruction register. Each instruction walks through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. Memory requests use req/ready
// handshakes that are bounded by a timeout. Timeouts and misaligned
// redirect targets trap into a sticky TRAP state that only rst leaves.
// Optional feature macro: PERF_COUNTERS_EN enables the cycle and retired-
// instruction counters. Without the macro both counter outputs are tied to 0.
module multi_cycle_sequencer #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 16,
    parameter int              CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Inst,
    input  logic             dec_RegWEn,
    input  logic             dec_MemRW,
    input  logic [1:0]       dec_WBSel,
    input  logic             dec_Jump,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  alu_result,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    input  logic             dmem_ready,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic [XLEN-1:0]  load_data,
    output logic             RegWEn,
    output logic [XLEN-1:0]  pc,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [1:0] CAUSE_IMEM_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGNED   = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TIMEOUT = 2'd3;

    // The wait counter holds 0..TIMEOUT_CYCLES-1. The request traps when
    // ready is still low while the counter sits on its last value.
    localparam int              WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        trap_cause;
    logic [WAIT_W-1:0] wait_cnt;

    logic is_mem_op;
    logic redirect;
    logic misaligned;
    logic [XLEN-1:0] redirect_target;

    // A load is identified by WBSel==0 (writeback from memory). A store is identified by MemRW.
    assign is_mem_op       = (dec_WBSel == 2'd0) || dec_MemRW;
    assign redirect        = dec_Jump || branch_taken;
    assign redirect_target = {alu_result[XLEN-1:1], 1'b0};
    // Bit 0 is cleared as JALR requires. A set bit 1 still breaks 4-byte alignment.
    assign misaligned      = redirect && redirect_target[1];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, including the trap cause for entry into TRAP.
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next = state;
        trap_cause = 2'd0;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (imem_ready) begin
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_TRAP;
                    trap_cause = CAUSE_IMEM_TIMEOUT;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    state_next = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_TRAP;
                    trap_cause = CAUSE_DMEM_TIMEOUT;
                end
            end
            S_WB: begin
                if (misaligned) begin
                    state_next = S_TRAP;
                    trap_cause = CAUSE_MISALIGNED;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    // Phase-gated strobes. All strobes are low outside their own phase.
    always_comb begin
        imem_req = (state == S_FETCH);
        dmem_req = (state == S_MEM);
        dmem_we  = (state == S_MEM) && dec_MemRW;
        RegWEn   = (state == S_WB) && dec_RegWEn && !misaligned;
    end

    assign imem_addr = pc;

    // PC, instruction register and the datapath latches, each updated in its own phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            Inst      <= '0;
            dmem_addr <= '0;
            load_data <= '0;
        end else begin
            case (state)
                S_FETCH: if (imem_ready) Inst <= imem_rdata;
                S_EXEC:  dmem_addr <= alu_result;
                S_MEM:   if (dmem_ready && !dec_MemRW) load_data <= dmem_rdata;
                S_WB: begin
                    if (!misaligned) begin
                        pc <= redirect ? redirect_target : pc + XLEN'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake wait counter. It clears on any state change, so it starts from 0 on entry to FETCH or MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky fault capture on entry to TRAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault       <= 1'b0;
            fault_cause <= 2'd0;
        end else if (state_next == S_TRAP && state != S_TRAP) begin
            fault       <= 1'b1;
            fault_cause <= trap_cause;
        end
    end

`ifdef PERF_COUNTERS_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instret_q;

    assign retire = (state == S_WB) && !misaligned;

    // Free-running cycle counter and retired-instruction counter. Both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Bench for multi_cycle_sequencer. Directed instruction vectors come from a
// table. Each vector is run from one FETCH to the next FETCH (or to TRAP) and
// then compared. Hand-written sequences follow for trap hold, reset recovery
// and reset during a memory access.
module tb_multi_cycle_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ready;
    logic [31:0]      imem_rdata;
    logic [31:0]      Inst;
    logic             dec_RegWEn;
    logic             dec_MemRW;
    logic [1:0]       dec_WBSel;
    logic             dec_Jump;
    logic             branch_taken;
    logic [XLEN-1:0]  alu_result;
    logic             dmem_req;
    logic             dmem_we;
    logic [XLEN-1:0]  dmem_addr;
    logic             dmem_ready;
    logic [XLEN-1:0]  dmem_rdata;
    logic [XLEN-1:0]  load_data;
    logic             RegWEn;
    logic [XLEN-1:0]  pc;
    logic             fault;
    logic [1:0]       fault_cause;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    always #5 clk = ~clk;

    multi_cycle_sequencer #(
        .XLEN(XLEN), .RESET_PC('0), .TIMEOUT_CYCLES(16), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Inst(Inst),
        .dec_RegWEn(dec_RegWEn), .dec_MemRW(dec_MemRW), .dec_WBSel(dec_WBSel), .dec_Jump(dec_Jump),
        .branch_taken(branch_taken), .alu_result(alu_result),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .load_data(load_data),
        .RegWEn(RegWEn), .pc(pc), .fault(fault), .fault_cause(fault_cause),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    typedef struct {
        string       name;
        bit          do_reset;
        int          fw;          // fetch wait cycles before imem_ready
        int          dw;          // data wait cycles before dmem_ready
        logic [31:0] inst;
        logic        regwen;
        logic        memrw;
        logic [1:0]  wbsel;
        logic        jump;
        logic        br;
        logic [31:0] alu;
        logic [31:0] rdata;
        bit          stray;       // raise ready while the matching req is low
        int          exp_cycles;
        logic [31:0] exp_pc_start;
        logic [31:0] exp_pc;
        int          exp_nreg;
        int          exp_nireq;
        int          exp_ndreq;
        int          exp_nwe;
        logic [31:0] exp_daddr;
        logic [31:0] exp_ld;
        logic [31:0] exp_inst;
        logic        exp_fault;
        logic [1:0]  exp_cause;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        dec_RegWEn   = 1'b0;
        dec_MemRW    = 1'b0;
        dec_WBSel    = 2'd1;
        dec_Jump     = 1'b0;
        branch_taken = 1'b0;
        alu_result   = '0;
        dmem_ready   = 1'b0;
        dmem_rdata   = '0;
    endtask

    // Reset, then step to the first FETCH cycle.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, nreg, nireq, ndreq, nwe, fcnt, dcnt;
        logic prev_req;
        logic [63:0] ir0;
        if (v.do_reset) do_reset();
        imem_rdata   = v.inst;
        dec_RegWEn   = v.regwen;
        dec_MemRW    = v.memrw;
        dec_WBSel    = v.wbsel;
        dec_Jump     = v.jump;
        branch_taken = v.br;
        alu_result   = v.alu;
        dmem_rdata   = v.rdata;
        check({v.name, "/start_addr"}, imem_addr, v.exp_pc_start);
        ir0 = instret_count;
        cyc = 0; nreg = 0; nireq = 0; ndreq = 0; nwe = 0; fcnt = 0; dcnt = 0;
        prev_req = 1'b1;
        while (cyc < 200) begin
            if (fault || (imem_req && !prev_req)) break;
            prev_req = imem_req;
            if (imem_req) nireq++;
            if (dmem_req) ndreq++;
            if (dmem_we)  nwe++;
            if (RegWEn)   nreg++;
            if (imem_req) begin
                imem_ready = (fcnt >= v.fw);
                if (!imem_ready) fcnt++;
            end else begin
                imem_ready = v.stray;
            end
            if (dmem_req) begin
                dmem_ready = (dcnt >= v.dw);
                if (!dmem_ready) dcnt++;
            end else begin
                dmem_ready = v.stray;
            end
            tick();
            cyc++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check({v.name, "/cycles"},    64'(cyc),   64'(v.exp_cycles));
        check({v.name, "/pc"},        pc,         v.exp_pc);
        check({v.name, "/regwen_cnt"}, 64'(nreg), 64'(v.exp_nreg));
        check({v.name, "/imem_req_cnt"}, 64'(nireq), 64'(v.exp_nireq));
        check({v.name, "/dmem_req_cnt"}, 64'(ndreq), 64'(v.exp_ndreq));
        check({v.name, "/dmem_we_cnt"}, 64'(nwe), 64'(v.exp_nwe));
        check({v.name, "/dmem_addr"}, dmem_addr,  v.exp_daddr);
        check({v.name, "/load_data"}, load_data,  v.exp_ld);
        check({v.name, "/inst"},      Inst,       v.exp_inst);
        check({v.name, "/fault"},     fault,      v.exp_fault);
        check({v.name, "/cause"},     fault_cause, v.exp_cause);
        check({v.name, "/strobes"}, {imem_req, dmem_req, dmem_we, RegWEn},
              v.exp_fault ? 4'b0000 : 4'b1000);
`ifdef PERF_COUNTERS_EN
        check({v.name, "/instret_delta"}, instret_count - ir0, v.exp_fault ? 64'd0 : 64'd1);
`else
        check({v.name, "/instret_zero"}, instret_count | ir0, 64'd0);
`endif
    endtask

    initial begin
        logic [3:0]  strobe_acc;
        logic [63:0] cyc0;

        // Columns: name rst fw dw inst regwen memrw wbsel jump br alu rdata stray |
        // cycles pc_start pc nreg nireq ndreq nwe daddr ld inst fault cause
        vecs[0]  = '{"addi0",     0, 0, 0, 32'h00100093, 1, 0, 2'd1, 0, 0, 32'h55,  32'h0, 0,
                     4, 32'h0,   32'h4,   1, 1, 0, 0, 32'h55,  32'h0,        32'h00100093, 0, 2'd0};
        vecs[1]  = '{"addi1",     0, 0, 0, 32'h00208113, 1, 0, 2'd1, 0, 0, 32'h66,  32'h0, 1,
                     4, 32'h4,   32'h8,   1, 1, 0, 0, 32'h66,  32'h0,        32'h00208113, 0, 2'd0};
        vecs[2]  = '{"alu_nowr",  0, 0, 0, 32'h00000013, 0, 0, 2'd1, 0, 0, 32'h77,  32'h0, 0,
                     4, 32'h8,   32'hC,   0, 1, 0, 0, 32'h77,  32'h0,        32'h00000013, 0, 2'd0};
        vecs[3]  = '{"load_w3",   0, 0, 3, 32'h00002183, 1, 0, 2'd0, 0, 0, 32'h200, 32'hDEADBEEF, 0,
                     8, 32'hC,   32'h10,  1, 1, 4, 0, 32'h200, 32'hDEADBEEF, 32'h00002183, 0, 2'd0};
        vecs[4]  = '{"store",     0, 0, 0, 32'h00302023, 0, 1, 2'd1, 0, 0, 32'h300, 32'h12345678, 0,
                     5, 32'h10,  32'h14,  0, 1, 1, 1, 32'h300, 32'hDEADBEEF, 32'h00302023, 0, 2'd0};
        vecs[5]  = '{"fetch_w2",  0, 2, 0, 32'h00108093, 1, 0, 2'd1, 0, 0, 32'h11,  32'h0, 0,
                     6, 32'h14,  32'h18,  1, 3, 0, 0, 32'h11,  32'hDEADBEEF, 32'h00108093, 0, 2'd0};
        vecs[6]  = '{"br_taken",  0, 0, 0, 32'h00000463, 0, 0, 2'd1, 0, 1, 32'h100, 32'h0, 0,
                     4, 32'h18,  32'h100, 0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 32'h00000463, 0, 2'd0};
        vecs[7]  = '{"br_not",    0, 0, 0, 32'h00000463, 0, 0, 2'd1, 0, 0, 32'h40,  32'h0, 0,
                     4, 32'h100, 32'h104, 0, 1, 0, 0, 32'h40,  32'hDEADBEEF, 32'h00000463, 0, 2'd0};
        vecs[8]  = '{"jalr_ok",   0, 0, 0, 32'h000080E7, 1, 0, 2'd2, 1, 0, 32'h101, 32'h0, 0,
                     4, 32'h104, 32'h100, 1, 1, 0, 0, 32'h101, 32'hDEADBEEF, 32'h000080E7, 0, 2'd0};
        vecs[9]  = '{"fetch_last",0, 15, 0, 32'h00110113, 1, 0, 2'd1, 0, 0, 32'h22, 32'h0, 0,
                     19, 32'h100, 32'h104, 1, 16, 0, 0, 32'h22, 32'hDEADBEEF, 32'h00110113, 0, 2'd0};
        vecs[10] = '{"load_last", 0, 0, 15, 32'h00402203, 1, 0, 2'd0, 0, 0, 32'h204, 32'hCAFEF00D, 0,
                     20, 32'h104, 32'h108, 1, 1, 16, 0, 32'h204, 32'hCAFEF00D, 32'h00402203, 0, 2'd0};
        vecs[11] = '{"jalr_misal",0, 0, 0, 32'h000080E7, 1, 0, 2'd2, 1, 0, 32'h103, 32'h0, 0,
                     4, 32'h108, 32'h108, 0, 1, 0, 0, 32'h103, 32'hCAFEF00D, 32'h000080E7, 1, 2'd2};
        vecs[12] = '{"imem_to",   1, 99, 0, 32'h00100093, 1, 0, 2'd1, 0, 0, 32'h55, 32'h0, 0,
                     16, 32'h0,  32'h0,   0, 16, 0, 0, 32'h0,  32'h0,        32'h0,        1, 2'd1};
        vecs[13] = '{"dmem_to",   1, 0, 99, 32'h00002183, 1, 0, 2'd0, 0, 0, 32'h208, 32'h0, 0,
                     19, 32'h0,  32'h0,   0, 1, 16, 0, 32'h208, 32'h0,       32'h00002183, 1, 2'd3};

        // Reset state.
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst/strobes", {imem_req, dmem_req, dmem_we, RegWEn}, 4'b0000);
        check("rst/pc", pc, 32'h0);
        check("rst/inst", Inst, 32'h0);
        check("rst/fault", {fault, fault_cause}, 3'b000);
        check("rst/load_data", load_data, 32'h0);
        check("rst/dmem_addr", dmem_addr, 32'h0);
        check("rst/counters", cycle_count | instret_count, 64'd0);
        rst = 1'b0;
        tick();
        check("cycle1/imem_req", imem_req, 1'b1);
        check("cycle1/imem_addr", imem_addr, 32'h0);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
            if (i == 2) begin
`ifdef PERF_COUNTERS_EN
                check("perf/cycle_count", cycle_count, 64'd13);
                check("perf/instret_count", instret_count, 64'd3);
`else
                check("perf/cycle_count", cycle_count, 64'd0);
                check("perf/instret_count", instret_count, 64'd0);
`endif
            end
        end

        // TRAP holds: strobes stay low even with ready high, and pc and cause stay frozen.
        strobe_acc = '0;
        cyc0 = cycle_count;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            strobe_acc |= {imem_req, dmem_req, dmem_we, RegWEn};
        end
        check("trap/strobes", strobe_acc, 4'b0000);
        check("trap/fault", {fault, fault_cause}, 3'b111);
        check("trap/pc", pc, 32'h0);
`ifdef PERF_COUNTERS_EN
        check("trap/cycle_delta", cycle_count - cyc0, 64'd5);
`else
        check("trap/cycle_delta", cycle_count | cyc0, 64'd0);
`endif

        // rst leaves TRAP and the fetch restarts at RESET_PC.
        do_reset();
        check("recover/fault", {fault, fault_cause}, 3'b000);
        check("recover/fetch", {imem_req, imem_addr}, {1'b1, 32'h0});

        // Reset during MEM aborts the access with no write and no retirement.
        imem_rdata = 32'h00002183;
        dec_RegWEn = 1'b1;
        dec_WBSel  = 2'd0;
        alu_result = 32'h40;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        check("midrst/in_mem", dmem_req, 1'b1);
        dmem_rdata = 32'hA5A5A5A5;
        dmem_ready = 1'b1;
        rst = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("midrst/strobes", {imem_req, dmem_req, dmem_we, RegWEn}, 4'b0000);
        check("midrst/load_data", load_data, 32'h0);
        check("midrst/pc", pc, 32'h0);
        rst = 1'b0;
        tick();
        check("midrst/refetch", {imem_req, imem_addr}, {1'b1, 32'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
